sof_rx: RTL and testbench
=========================

Name: sof_rx

Overview:
- Receive-side start-of-frame detector for the CAN controller; the counterpart of the SOF transmitter.
- Watches the synchronised bus bit and declares the bus idle after IDLE_BITS consecutive recessive samples.
- On a recessive-to-dominant edge while idle, requests a hard sync, then validates SOF at the next sample point.
- Reports either a valid SOF (frame start for the bit-stream receiver) or a glitch, and holds frame state until the receiver signals end of frame.

Parameters:
- IDLE_BITS, 11, consecutive recessive samples required to declare bus idle (7 EOF + 3 intermission + 1 margin).
- SYNC_TIMEOUT, 64, clock cycles allowed between hard sync and the validating sample point.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low forces the restart state.
- rx_bit  input  1  synchronised bus level (1 = recessive, 0 = dominant).
- sample_point  input  1  one-cycle pulse from bit timing marking the bit sample instant.
- frame_done  input  1  one-cycle pulse from the frame receiver at end of frame or on error.
- bus_idle  output  1  level, bus idle.
- hard_sync  output  1  one-cycle pulse requesting hard synchronisation.
- sof_received  output  1  one-cycle pulse, valid SOF confirmed.
- sof_glitch  output  1  one-cycle pulse, edge not confirmed dominant at sample point.
- sync_timeout  output  1  one-cycle pulse, no sample point within SYNC_TIMEOUT.
- frame_active  output  1  level, frame in progress.

Behaviour:
- Reset (synchronous, active-high) overrides everything.
  - Values after reset: state = WAIT_IDLE, idle_cnt = 0, wait_cnt = 0, rx_prev = 1, all outputs 0.
- enable = 0 (evaluated after reset) has the same effect as reset. Re-enabling restarts idle counting from 0.
- All outputs are registered.
  - Pulse outputs are high for exactly one cycle, in the cycle after their triggering condition is sampled.
- rx_prev <= rx_bit every enabled cycle. fall = rx_prev & ~rx_bit.
- idle_cnt width is clog2(IDLE_BITS+1). wait_cnt width is clog2(SYNC_TIMEOUT+1). Neither counter wraps: each saturates or clears as stated below.
- State machine:
  - WAIT_IDLE:
    - On sample_point with rx_bit = 1: idle_cnt += 1.
    - On sample_point with rx_bit = 0: idle_cnt = 0.
    - When the increment makes idle_cnt = IDLE_BITS: go to IDLE, bus_idle = 1 from the next cycle, idle_cnt cleared.
    - fall events are ignored here.
  - IDLE:
    - bus_idle = 1.
    - On fall: go to SYNC, pulse hard_sync, clear wait_cnt, bus_idle = 0.
    - sample_point in IDLE does nothing.
    - fall together with sample_point in the same cycle: fall wins and sample_point is discarded (the hard sync restarts the bit).
  - SYNC:
    - wait_cnt += 1 per cycle.
    - On sample_point with rx_bit = 0: pulse sof_received, go to FRAME, frame_active = 1.
    - On sample_point with rx_bit = 1: pulse sof_glitch, return to IDLE (bus_idle = 1 again). Idle status is retained.
    - If wait_cnt reaches SYNC_TIMEOUT with no sample_point: pulse sync_timeout, go to WAIT_IDLE, idle_cnt = 0.
    - sample_point in the same cycle that wait_cnt reaches SYNC_TIMEOUT: the sample point wins.
    - Further fall events in SYNC are ignored; no second hard_sync is issued.
  - FRAME:
    - frame_active = 1.
    - fall and sample_point are ignored.
    - On frame_done: frame_active = 0 next cycle, go to WAIT_IDLE, idle_cnt = 0.
    - frame_done outside FRAME is ignored.
- Exclusivity:
  - At most one of hard_sync, sof_received, sof_glitch, sync_timeout is high in any cycle.
  - bus_idle and frame_active are never both high.

Test Plan:
- Idle detection: after reset, enable = 1, rx_bit = 1, 11 sample_point pulses 10 cycles apart → bus_idle rises 1 cycle after the 11th pulse. After only 10 pulses, bus_idle is still 0.
- Counter clear: rx_bit = 1 for 6 sample points, rx_bit = 0 at the 7th, then rx_bit = 1 → bus_idle rises only after 11 further recessive sample points (17 recessive in total).
- Valid SOF: from IDLE, drive rx_bit 1→0 → hard_sync high for exactly 1 cycle, bus_idle = 0. Sample point 4 cycles later with rx_bit = 0 → sof_received 1 cycle later, frame_active = 1. frame_done pulse → frame_active = 0 next cycle, state WAIT_IDLE.
- Glitch: from IDLE, rx_bit 1→0 for 2 cycles then back to 1 before the sample point → hard_sync pulse, then sof_glitch pulse after the sample point, bus_idle = 1 again, frame_active stays 0.
- Timeout and collision: edge with no sample_point for 64 cycles → sync_timeout pulse, bus_idle = 0, 11 recessive samples needed again. Separately, fall coincident with sample_point in IDLE → hard_sync only, no sof_received in that cycle.
- Reset/enable mid-operation: reset = 1 for 1 cycle while in FRAME → all outputs 0 on the next cycle. enable = 0 in SYNC → no sof_received even if sample_point arrives, and after re-enable bus_idle requires 11 fresh recessive samples.

Source files
------------

// File: rtl/sof_rx.sv
// rtl/sof_rx.sv - CAN receive-side start-of-frame detector
module sof_rx #(
  parameter int IDLE_BITS    = 11,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic rx_bit,
  input  logic sample_point,
  input  logic frame_done,
  output logic bus_idle,
  output logic hard_sync,
  output logic sof_received,
  output logic sof_glitch,
  output logic sync_timeout,
  output logic frame_active
);

  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int WW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SYNC, FRAME} state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wait_cnt;
  logic          rx_prev;
  logic          fall;

  assign fall = rx_prev & ~rx_bit;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state        <= WAIT_IDLE;
      idle_cnt     <= '0;
      wait_cnt     <= '0;
      rx_prev      <= 1'b1;
      bus_idle     <= 1'b0;
      hard_sync    <= 1'b0;
      sof_received <= 1'b0;
      sof_glitch   <= 1'b0;
      sync_timeout <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      rx_prev      <= rx_bit;
      hard_sync    <= 1'b0;
      sof_received <= 1'b0;
      sof_glitch   <= 1'b0;
      sync_timeout <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (sample_point) begin
            if (!rx_bit) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_LAST) begin
              state    <= IDLE;
              idle_cnt <= '0;
              bus_idle <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end
        IDLE: begin
          // A falling edge restarts the bit, so a coincident sample point is dropped.
          if (fall) begin
            state     <= SYNC;
            hard_sync <= 1'b1;
            wait_cnt  <= '0;
            bus_idle  <= 1'b0;
          end
        end
        SYNC: begin
          if (sample_point) begin
            if (!rx_bit) begin
              state        <= FRAME;
              sof_received <= 1'b1;
              frame_active <= 1'b1;
            end else begin
              state      <= IDLE;
              sof_glitch <= 1'b1;
              bus_idle   <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= WAIT_IDLE;
            sync_timeout <= 1'b1;
            idle_cnt     <= '0;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        FRAME: begin
          if (frame_done) begin
            state        <= WAIT_IDLE;
            frame_active <= 1'b0;
            idle_cnt     <= '0;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sof_rx.sv
// tb/tb_sof_rx.sv - randomized and directed check of sof_rx against a behavioural model
module tb_sof_rx;

  localparam int IDLE_BITS    = 11;
  localparam int SYNC_TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset, enable, rx_bit, sample_point, frame_done;
  logic bus_idle, hard_sync, sof_received, sof_glitch, sync_timeout, frame_active;

  int total = 0;
  int bad = 0;

  sof_rx #(.IDLE_BITS(IDLE_BITS), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_bit(rx_bit),
    .sample_point(sample_point), .frame_done(frame_done),
    .bus_idle(bus_idle), .hard_sync(hard_sync), .sof_received(sof_received),
    .sof_glitch(sof_glitch), .sync_timeout(sync_timeout), .frame_active(frame_active)
  );

  always #5 clock = ~clock;

  // Model: bus view as a recessive run length, an idle flag, a sync age (-1 = not syncing) and a frame flag.
  bit m_prev = 1'b1;
  int m_run = 0;
  bit m_idle = 1'b0;
  int m_age = -1;
  bit m_frame = 1'b0;
  bit e_hs, e_sof, e_gl, e_to;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit rx, input bit sp, input bit fd);
    bit fall;
    e_hs = 0; e_sof = 0; e_gl = 0; e_to = 0;
    if (r || !en) begin
      m_prev = 1; m_run = 0; m_idle = 0; m_age = -1; m_frame = 0;
      return;
    end
    fall = m_prev && !rx;
    m_prev = rx;
    if (m_frame) begin
      if (fd) begin m_frame = 0; m_run = 0; end
    end else if (m_age >= 0) begin
      if (sp) begin
        if (!rx) begin e_sof = 1; m_frame = 1; end
        else begin e_gl = 1; m_idle = 1; end
        m_age = -1;
      end else begin
        m_age++;
        if (m_age == SYNC_TIMEOUT) begin e_to = 1; m_age = -1; m_run = 0; end
      end
    end else if (m_idle) begin
      if (fall) begin e_hs = 1; m_idle = 0; m_age = 0; end
    end else if (sp) begin
      m_run = rx ? m_run + 1 : 0;
      if (m_run == IDLE_BITS) begin m_idle = 1; m_run = 0; end
    end
  endtask

  task automatic tick();
    bit r, en, rx, sp, fd;
    r = reset; en = enable; rx = rx_bit; sp = sample_point; fd = frame_done;
    @(posedge clock);
    #1;
    model_step(r, en, rx, sp, fd);
    check("bus_idle", bus_idle, m_idle);
    check("frame_active", frame_active, m_frame);
    check("hard_sync", hard_sync, e_hs);
    check("sof_received", sof_received, e_sof);
    check("sof_glitch", sof_glitch, e_gl);
    check("sync_timeout", sync_timeout, e_to);
    check("pulse_excl", (32'(hard_sync) + 32'(sof_received) + 32'(sof_glitch) + 32'(sync_timeout)) <= 1, 1);
    check("level_excl", bus_idle & frame_active, 0);
  endtask

  task automatic pulses(input int n, input bit rx, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_bit = rx;
      sample_point = 1;
      tick();
      sample_point = 0;
      repeat (gap - 1) tick();
    end
  endtask

  initial begin
    reset = 1; enable = 1; rx_bit = 1; sample_point = 0; frame_done = 0;
    tick(); tick();
    reset = 0;

    // idle detection: 10 pulses not enough, 11th completes
    pulses(10, 1, 10);
    check("idle_after_10", bus_idle, 0);
    pulses(1, 1, 1);
    check("idle_after_11", bus_idle, 1);

    // valid SOF then frame_done
    rx_bit = 0; tick();
    check("sof_hard_sync", hard_sync, 1);
    repeat (3) tick();
    pulses(1, 0, 1);
    check("sof_pulse", sof_received, 1);
    repeat (5) tick();
    rx_bit = 1; frame_done = 1; tick(); frame_done = 0;
    check("frame_end", frame_active, 0);

    // counter clear: 6 recessive, 1 dominant, then 11 recessive
    pulses(6, 1, 5);
    pulses(1, 0, 5);
    pulses(10, 1, 5);
    check("clear_not_idle", bus_idle, 0);
    pulses(1, 1, 3);
    check("clear_idle", bus_idle, 1);

    // glitch
    rx_bit = 0; tick(); tick();
    rx_bit = 1; tick(); tick();
    pulses(1, 1, 1);
    check("glitch_pulse", sof_glitch, 1);
    check("glitch_idle", bus_idle, 1);

    // timeout
    rx_bit = 0;
    repeat (SYNC_TIMEOUT + 4) tick();
    rx_bit = 1;
    check("timeout_idle", bus_idle, 0);
    pulses(11, 1, 4);
    check("timeout_reidle", bus_idle, 1);

    // fall coincident with sample point, then SOF, then reset in FRAME
    rx_bit = 0; sample_point = 1; tick(); sample_point = 0;
    check("collide_hs", hard_sync, 1);
    check("collide_no_sof", sof_received, 0);
    tick();
    pulses(1, 0, 1);
    check("collide_frame", frame_active, 1);
    reset = 1; tick(); reset = 0;
    check("reset_frame", frame_active, 0);
    rx_bit = 1; tick();

    // disable during SYNC
    pulses(11, 1, 3);
    rx_bit = 0; tick(); tick();
    enable = 0; sample_point = 1; tick(); sample_point = 0;
    check("disable_no_sof", sof_received, 0);
    enable = 1; rx_bit = 1;
    pulses(10, 1, 3);
    check("reenable_not_idle", bus_idle, 0);
    pulses(1, 1, 3);
    check("reenable_idle", bus_idle, 1);

    // randomized traffic
    begin
      int period = 6;
      int dom_left = 0;
      for (int c = 0; c < 6000; c++) begin
        if ($urandom_range(0, 99) == 0) period = $urandom_range(3, 12);
        if (dom_left > 0) dom_left--;
        else if ($urandom_range(0, 59) == 0) dom_left = $urandom_range(1, 14);
        rx_bit = (dom_left == 0);
        sample_point = ((c % period) == 0) && ($urandom_range(0, 19) != 0);
        frame_done = ($urandom_range(0, 39) == 0);
        enable = ($urandom_range(0, 399) != 0);
        reset = ($urandom_range(0, 799) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
